// File: rtl/bitcoin_nonce_sequencer_pkg.sv
// Shared types, SHA-256 constants and the message-block builder for the nonce sequencer.
package bitcoin_nonce_sequencer_pkg;

    typedef logic [31:0]       word_t;
    typedef logic [7:0][31:0]  hash_t;   // element 0 is H0
    typedef logic [2:0][31:0]  tail_t;   // element 0 is header word 16
    typedef logic [15:0][31:0] msg_t;    // element 0 is message word 0

    localparam hash_t SHA256_IV = {
        32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
        32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
    };

    localparam word_t PAD_WORD = 32'h80000000;
    localparam word_t LEN_P1   = 32'd640;
    localparam word_t LEN_P2   = 32'd256;

    typedef enum logic [2:0] {
        S_IDLE,
        S_P1_START,
        S_P1_WAIT,
        S_P2_START,
        S_P2_WAIT,
        S_EMIT,
        S_FINISH
    } seq_state_t;

    typedef enum logic {
        PASS_1,
        PASS_2
    } pass_t;

    // Pass 1 finishes the 80-byte header; pass 2 hashes the 32-byte pass-1 digest.
    function automatic msg_t build_msg(input pass_t pass, input tail_t tail,
                                       input word_t nonce, input hash_t p1);
        msg_t m;
        m = '0;
        if (pass == PASS_1) begin
            m[0]  = tail[0];
            m[1]  = tail[1];
            m[2]  = tail[2];
            m[3]  = nonce;
            m[4]  = PAD_WORD;
            m[15] = LEN_P1;
        end else begin
            for (int i = 0; i < 8; i++) begin
                m[i] = p1[i];
            end
            m[8]  = PAD_WORD;
            m[15] = LEN_P2;
        end
        return m;
    endfunction

endpackage

// File: rtl/bitcoin_nonce_sequencer_if.sv
// Compression-core request/response lines and the result stream of the nonce sequencer.
interface bitcoin_nonce_sequencer_if;
    import bitcoin_nonce_sequencer_pkg::*;

    logic  core_start;
    msg_t  core_message;
    hash_t core_starter_hash;
    logic  core_done;
    hash_t core_hash;

    logic  result_valid;
    logic  result_ready;
    word_t result_nonce;
    hash_t result_hash;

    modport master (
        output core_start,
        output core_message,
        output core_starter_hash,
        input  core_done,
        input  core_hash,
        output result_valid,
        input  result_ready,
        output result_nonce,
        output result_hash
    );

    modport slave (
        input  core_start,
        input  core_message,
        input  core_starter_hash,
        output core_done,
        output core_hash,
        input  result_valid,
        output result_ready,
        input  result_nonce,
        input  result_hash
    );

endinterface

// File: rtl/bitcoin_nonce_sequencer.sv
// Sweeps a nonce range, running two compression passes per nonce (SHA256d) and streaming results.
module bitcoin_nonce_sequencer
    import bitcoin_nonce_sequencer_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  hash_t                  midstate,
    input  tail_t                  header_tail,
    input  word_t                  nonce_base,
    input  logic [CNT_W-1:0]       num_nonces,
    bitcoin_nonce_sequencer_if.master bus,
    output logic                   busy,
    output logic                   done
);

    seq_state_t       state_q, state_d;
    hash_t            mid_q, mid_d;
    tail_t            tail_q, tail_d;
    word_t            nonce_q, nonce_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    hash_t            p1_q, p1_d;

    logic             core_start_q, core_start_d;
    msg_t             core_msg_q, core_msg_d;
    hash_t            core_sh_q, core_sh_d;
    logic             result_valid_q, result_valid_d;
    word_t            result_nonce_q, result_nonce_d;
    hash_t            result_hash_q, result_hash_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    always_comb begin
        state_d        = state_q;
        mid_d          = mid_q;
        tail_d         = tail_q;
        nonce_d        = nonce_q;
        remaining_d    = remaining_q;
        p1_d           = p1_q;
        core_msg_d     = core_msg_q;
        core_sh_d      = core_sh_q;
        result_nonce_d = result_nonce_q;
        result_hash_d  = result_hash_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    mid_d       = midstate;
                    tail_d      = header_tail;
                    nonce_d     = nonce_base;
                    remaining_d = num_nonces;
                    state_d     = (num_nonces == '0) ? S_FINISH : S_P1_START;
                end
            end
            S_P1_START: state_d = S_P1_WAIT;
            S_P1_WAIT: begin
                if (bus.core_done) begin
                    p1_d    = bus.core_hash;
                    state_d = S_P2_START;
                end
            end
            S_P2_START: state_d = S_P2_WAIT;
            S_P2_WAIT: begin
                if (bus.core_done) begin
                    result_hash_d  = bus.core_hash;
                    result_nonce_d = nonce_q;
                    state_d        = S_EMIT;
                end
            end
            S_EMIT: begin
                if (bus.result_ready) begin
                    nonce_d     = nonce_q + 32'd1;
                    remaining_d = remaining_q - CNT_W'(1);
                    state_d     = (remaining_q == CNT_W'(1)) ? S_FINISH : S_P1_START;
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase

        // Core operands are built from the next-state values so a pass launched straight
        // out of IDLE or EMIT already sees the freshly latched or incremented nonce.
        if (state_d == S_P1_START) begin
            core_msg_d = build_msg(PASS_1, tail_d, nonce_d, p1_d);
            core_sh_d  = mid_d;
        end else if (state_d == S_P2_START) begin
            core_msg_d = build_msg(PASS_2, tail_d, nonce_d, p1_d);
            core_sh_d  = SHA256_IV;
        end

        core_start_d   = (state_d == S_P1_START) || (state_d == S_P2_START);
        result_valid_d = (state_d == S_EMIT);
        done_d         = (state_d == S_FINISH);
        busy_d         = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= S_IDLE;
            mid_q          <= '0;
            tail_q         <= '0;
            nonce_q        <= '0;
            remaining_q    <= '0;
            p1_q           <= '0;
            core_start_q   <= 1'b0;
            core_msg_q     <= '0;
            core_sh_q      <= '0;
            result_valid_q <= 1'b0;
            result_nonce_q <= '0;
            result_hash_q  <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            mid_q          <= mid_d;
            tail_q         <= tail_d;
            nonce_q        <= nonce_d;
            remaining_q    <= remaining_d;
            p1_q           <= p1_d;
            core_start_q   <= core_start_d;
            core_msg_q     <= core_msg_d;
            core_sh_q      <= core_sh_d;
            result_valid_q <= result_valid_d;
            result_nonce_q <= result_nonce_d;
            result_hash_q  <= result_hash_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
        end
    end

    assign bus.core_start        = core_start_q;
    assign bus.core_message      = core_msg_q;
    assign bus.core_starter_hash = core_sh_q;
    assign bus.result_valid      = result_valid_q;
    assign bus.result_nonce      = result_nonce_q;
    assign bus.result_hash       = result_hash_q;
    assign busy                  = busy_q;
    assign done                  = done_q;

endmodule

// File: tb/tb_bitcoin_nonce_sequencer.sv
// Bench for the nonce sequencer: behavioural SHA-256 core, SHA256d reference queue and directed sweeps.
module tb_bitcoin_nonce_sequencer;
    import bitcoin_nonce_sequencer_pkg::*;

    localparam int CORE_LAT = 68;

    typedef struct {
        word_t nonce;
        hash_t p1;
        hash_t h;
    } exp_t;

    localparam word_t K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam word_t IV_W [8] = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                   32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    localparam word_t ABC_W [8] = '{32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
                                    32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};

    localparam hash_t MID = {32'h8899aabb, 32'h77665544, 32'h33221100, 32'hdeadbeef,
                             32'h0badf00d, 32'hcafef00d, 32'h13579bdf, 32'h2468ace0};
    localparam tail_t TAIL = {32'h1d00ffff, 32'h5f5e1000, 32'h4a5e1e4b};

    logic             clk;
    logic             reset_n;
    logic             start;
    hash_t            midstate;
    tail_t            header_tail;
    word_t            nonce_base;
    logic [15:0]      num_nonces;
    logic             busy;
    logic             done;
    logic             result_ready;
    logic             inj_done;
    logic             model_done;
    hash_t            model_hash;
    logic             m_active;
    int               m_cnt;
    hash_t            m_sh;
    msg_t             m_msg;

    int               n_checks;
    int               n_err;
    int               n_results;
    int               n_core_starts;
    int               n_dones;
    word_t            acc[$];

    bitcoin_nonce_sequencer_if bus ();

    bitcoin_nonce_sequencer #(.CNT_W(16)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .midstate    (midstate),
        .header_tail (header_tail),
        .nonce_base  (nonce_base),
        .num_nonces  (num_nonces),
        .bus         (bus),
        .busy        (busy),
        .done        (done)
    );

    assign bus.core_done    = model_done | inj_done;
    assign bus.core_hash    = model_hash;
    assign bus.result_ready = result_ready;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic word_t rotr(input word_t x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic hash_t sha_compress(input hash_t hin, input msg_t m);
        word_t w [64];
        word_t a, b, c, d, e, f, g, h, t1, t2, s0, s1;
        hash_t r;
        for (int i = 0; i < 16; i++) w[i] = m[i];
        for (int i = 16; i < 64; i++) begin
            s0 = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
            s1 = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = w[i-16] + s0 + w[i-7] + s1;
        end
        a = hin[0]; b = hin[1]; c = hin[2]; d = hin[3];
        e = hin[4]; f = hin[5]; g = hin[6]; h = hin[7];
        for (int i = 0; i < 64; i++) begin
            t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
            t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            h = g; g = f; f = e; e = d + t1;
            d = c; c = b; b = a; a = t1 + t2;
        end
        r[0] = hin[0] + a; r[1] = hin[1] + b; r[2] = hin[2] + c; r[3] = hin[3] + d;
        r[4] = hin[4] + e; r[5] = hin[5] + f; r[6] = hin[6] + g; r[7] = hin[7] + h;
        return r;
    endfunction

    function automatic hash_t from_words(input word_t v [8]);
        hash_t r;
        for (int i = 0; i < 8; i++) r[i] = v[i];
        return r;
    endfunction

    // Header block 2: 12 tail bytes, nonce, padding, bit length of the 80-byte header.
    function automatic msg_t msg_hdr(input tail_t t, input word_t n);
        msg_t m;
        m = '0;
        m[0] = t[0]; m[1] = t[1]; m[2] = t[2]; m[3] = n;
        m[4] = 32'h80000000; m[15] = 32'd640;
        return m;
    endfunction

    // Single block holding a 32-byte digest, padding and a 256-bit length.
    function automatic msg_t msg_dig(input hash_t p);
        msg_t m;
        m = '0;
        for (int i = 0; i < 8; i++) m[i] = p[i];
        m[8] = 32'h80000000; m[15] = 32'd256;
        return m;
    endfunction

    // Behavioural compression core: starter hash taken at start, message two cycles later.
    always @(negedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_active   <= 1'b0;
            m_cnt      <= 0;
            m_sh       <= '0;
            m_msg      <= '0;
            model_done <= 1'b0;
            model_hash <= '0;
        end else begin
            model_done <= 1'b0;
            if (bus.core_start && !m_active) begin
                m_active <= 1'b1;
                m_cnt    <= 1;
                m_sh     <= bus.core_starter_hash;
            end else if (m_active) begin
                m_cnt <= m_cnt + 1;
                if (m_cnt == 2) m_msg <= bus.core_message;
                if (m_cnt == CORE_LAT) begin
                    model_done <= 1'b1;
                    model_hash <= sha_compress(m_sh, m_msg);
                    m_active   <= 1'b0;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    // sel: 0 core_start, 1 done, 2 result_valid
    task automatic wait_ev(input int sel, input int max, input string name);
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if ((sel == 0 && bus.core_start) || (sel == 1 && done) || (sel == 2 && bus.result_valid))
                return;
        end
        n_checks++;
        n_err++;
        $display("FAIL timeout_%s: waited=%0d cycles required<%0d", name, max, max);
    endtask

    task automatic do_start(input word_t base, input logic [15:0] n);
        @(posedge clk); #1;
        nonce_base  = base;
        num_nonces  = n;
        midstate    = MID;
        header_tail = TAIL;
        start       = 1'b1;
        @(posedge clk); #1;
        start       = 1'b0;
    endtask

    // Reference model: queue of expected SHA256d results, checked on every meaningful cycle.
    task automatic monitor();
        exp_t  q[$];
        exp_t  e;
        bit    in_sweep, exp_done, nxt_done, pass2, holding;
        msg_t  em, hmsg;
        hash_t esh, hsh, mid_l;
        tail_t tail_l;
        in_sweep = 0; exp_done = 0; pass2 = 0; holding = 0;
        hmsg = '0; hsh = '0; mid_l = '0; tail_l = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                q.delete();
                in_sweep = 0; exp_done = 0; pass2 = 0; holding = 0;
                continue;
            end
            chk("busy", 512'(busy), 512'(in_sweep));
            chk("done", 512'(done), 512'(exp_done));
            nxt_done = 0;
            if (done) begin
                in_sweep = 0;
                n_dones++;
            end
            if (start && !busy) begin
                in_sweep = 1; pass2 = 0; holding = 0;
                mid_l = midstate; tail_l = header_tail;
                for (int k = 0; k < int'(num_nonces); k++) begin
                    e.nonce = nonce_base + word_t'(k);
                    e.p1    = sha_compress(mid_l, msg_hdr(tail_l, e.nonce));
                    e.h     = sha_compress(from_words(IV_W), msg_dig(e.p1));
                    q.push_back(e);
                end
                if (num_nonces == 16'd0) nxt_done = 1;
            end
            if (bus.core_start) begin
                n_core_starts++;
                chk("core_start_allowed", 512'(in_sweep && q.size() > 0 && !bus.result_valid), 512'(1));
                if (q.size() > 0) begin
                    em  = pass2 ? msg_dig(q[0].p1) : msg_hdr(tail_l, q[0].nonce);
                    esh = pass2 ? from_words(IV_W) : mid_l;
                    chk("core_message", bus.core_message, em);
                    chk("core_starter_hash", 512'(bus.core_starter_hash), 512'(esh));
                    hmsg = em; hsh = esh;
                end
                pass2 = !pass2;
                holding = 1;
            end else if (holding) begin
                if (bus.core_done) begin
                    holding = 0;
                end else begin
                    chk("core_message_hold", bus.core_message, hmsg);
                    chk("core_starter_hold", 512'(bus.core_starter_hash), 512'(hsh));
                end
            end
            if (bus.result_valid) begin
                if (q.size() == 0) begin
                    chk("result_expected", 512'(0), 512'(1));
                end else begin
                    chk("result_nonce", 512'(bus.result_nonce), 512'(q[0].nonce));
                    chk("result_hash", 512'(bus.result_hash), 512'(q[0].h));
                    if (result_ready) begin
                        acc.push_back(q[0].nonce);
                        void'(q.pop_front());
                        n_results++;
                        if (q.size() == 0) nxt_done = 1;
                    end
                end
            end
            exp_done = nxt_done;
        end
    endtask

    initial begin
        int r0, c0, d0;
        n_checks = 0; n_err = 0; n_results = 0; n_core_starts = 0; n_dones = 0;
        reset_n = 1'b0; start = 1'b0; midstate = '0; header_tail = '0;
        nonce_base = '0; num_nonces = '0; result_ready = 1'b1; inj_done = 1'b0;
        fork
            monitor();
        join_none

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_core_start", 512'(bus.core_start), 512'(0));
        chk("rst_result_valid", 512'(bus.result_valid), 512'(0));
        chk("rst_done", 512'(done), 512'(0));
        chk("rst_busy", 512'(busy), 512'(0));
        chk("rst_core_message", bus.core_message, 512'(0));
        chk("rst_result_hash", 512'(bus.result_hash), 512'(0));
        @(posedge clk); #1 reset_n = 1'b1;

        // pin the reference compression function: SHA-256("abc")
        begin
            msg_t abc;
            abc = '0; abc[0] = 32'h61626380; abc[15] = 32'h00000018;
            chk("model_sha256_abc", 512'(sha_compress(from_words(IV_W), abc)), 512'(from_words(ABC_W)));
        end

        // empty sweep
        c0 = n_core_starts;
        do_start(32'h00000000, 16'd0);
        @(negedge clk);
        chk("n0_done_pulse", 512'(done), 512'(1));
        @(negedge clk);
        chk("n0_done_low", 512'(done), 512'(0));
        chk("n0_busy_low", 512'(busy), 512'(0));
        chk("n0_no_core_start", 512'(n_core_starts - c0), 512'(0));

        // single nonce, literal message fields
        acc.delete(); r0 = n_results;
        do_start(32'h12345678, 16'd1);
        wait_ev(0, 10, "p1_start");
        chk("p1_msg3", 512'(bus.core_message[3]), 512'(32'h12345678));
        chk("p1_msg4", 512'(bus.core_message[4]), 512'(32'h80000000));
        chk("p1_msg15", 512'(bus.core_message[15]), 512'(32'h00000280));
        chk("p1_starter", 512'(bus.core_starter_hash), 512'(MID));
        wait_ev(0, 200, "p2_start");
        chk("p2_msg8", 512'(bus.core_message[8]), 512'(32'h80000000));
        chk("p2_msg15", 512'(bus.core_message[15]), 512'(32'h00000100));
        chk("p2_starter_h0", 512'(bus.core_starter_hash[0]), 512'(32'h6a09e667));
        chk("p2_starter_h7", 512'(bus.core_starter_hash[7]), 512'(32'h5be0cd19));
        wait_ev(1, 300, "n1_done");
        @(posedge clk); #1;
        chk("n1_results", 512'(n_results - r0), 512'(1));
        chk("n1_nonce", 512'(acc.size() > 0 ? acc[0] : 32'hxxxxxxxx), 512'(32'h12345678));

        // nonce wrap
        acc.delete(); r0 = n_results; d0 = n_dones;
        do_start(32'hFFFFFFFE, 16'd3);
        wait_ev(1, 1000, "wrap_done");
        @(posedge clk); #1;
        chk("wrap_count", 512'(acc.size()), 512'(3));
        if (acc.size() == 3) begin
            chk("wrap_n0", 512'(acc[0]), 512'(32'hFFFFFFFE));
            chk("wrap_n1", 512'(acc[1]), 512'(32'hFFFFFFFF));
            chk("wrap_n2", 512'(acc[2]), 512'(32'h00000000));
        end
        chk("wrap_one_done", 512'(n_dones - d0), 512'(1));

        // consumer stall
        result_ready = 1'b0;
        do_start(32'h00000100, 16'd2);
        wait_ev(2, 300, "stall_valid");
        c0 = n_core_starts;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("stall_valid", 512'(bus.result_valid), 512'(1));
            chk("stall_nonce", 512'(bus.result_nonce), 512'(32'h00000100));
        end
        chk("stall_no_core_start", 512'(n_core_starts - c0), 512'(0));
        @(posedge clk); #1 result_ready = 1'b1;
        wait_ev(0, 3, "stall_release_p1");
        chk("release_msg3", 512'(bus.core_message[3]), 512'(32'h00000101));
        wait_ev(1, 400, "stall_done");

        // ignored start and spurious core_done
        result_ready = 1'b0; r0 = n_results; c0 = n_core_starts;
        do_start(32'h0000AAAA, 16'd2);
        wait_ev(0, 10, "ign_p1");
        repeat (5) @(posedge clk);
        #1; nonce_base = 32'h0000DEAD; num_nonces = 16'd5; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_ev(2, 300, "ign_valid");
        @(posedge clk); #1 inj_done = 1'b1;
        @(posedge clk); #1 inj_done = 1'b0;
        @(negedge clk);
        chk("spur_valid", 512'(bus.result_valid), 512'(1));
        chk("spur_nonce", 512'(bus.result_nonce), 512'(32'h0000AAAA));
        chk("spur_no_core_start", 512'(bus.core_start), 512'(0));
        @(posedge clk); #1 result_ready = 1'b1;
        wait_ev(1, 400, "ign_done");
        @(posedge clk); #1;
        chk("ign_results", 512'(n_results - r0), 512'(2));
        chk("ign_core_starts", 512'(n_core_starts - c0), 512'(4));

        // reset during P2_WAIT, then a clean sweep
        do_start(32'h00005000, 16'd3);
        wait_ev(0, 10, "abort_p1");
        wait_ev(0, 200, "abort_p2");
        repeat (10) @(posedge clk);
        #1 reset_n = 1'b0;
        @(negedge clk);
        chk("abort_core_start", 512'(bus.core_start), 512'(0));
        chk("abort_valid", 512'(bus.result_valid), 512'(0));
        chk("abort_done", 512'(done), 512'(0));
        chk("abort_busy", 512'(busy), 512'(0));
        chk("abort_nonce", 512'(bus.result_nonce), 512'(0));
        chk("abort_starter", 512'(bus.core_starter_hash), 512'(0));
        @(posedge clk); #1 reset_n = 1'b1;
        acc.delete(); r0 = n_results;
        do_start(32'h00007000, 16'd2);
        wait_ev(1, 600, "clean_done");
        @(posedge clk); #1;
        chk("clean_results", 512'(n_results - r0), 512'(2));
        if (acc.size() == 2) begin
            chk("clean_n0", 512'(acc[0]), 512'(32'h00007000));
            chk("clean_n1", 512'(acc[1]), 512'(32'h00007001));
        end else begin
            chk("clean_count", 512'(acc.size()), 512'(2));
        end

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
